imem_loader: RTL and testbench

Byte-stream program loader that writes 16-bit instruction words into the instruction memory read by the CPU's fetch path. It accepts a length-prefixed byte stream over a valid/ready handshake, assembles big-endian words, and issues one write per word at sequential addresses starting at 0. It holds the CPU in reset until the load completes, then releases it so the program starts at pc 0.

---
 rtl/imem_loader.sv | 149 ++++++++++++++
 tb/tb_imem_loader.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Length-prefixed byte-stream loader: assembles big-endian 16-bit words into instruction memory and holds the CPU until done.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CKSUM_EN.
module imem_loader #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_HDR_HI,
        S_HDR_LO,
        S_DAT_HI,
        S_DAT_LO,
        S_DONE,
        S_ERR
`ifdef IMEM_LOADER_CKSUM_EN
        , S_CKSUM
`endif
    } state_t;

`ifdef IMEM_LOADER_CKSUM_EN
    localparam state_t S_END = S_CKSUM;
`else
    localparam state_t S_END = S_DONE;
`endif

    state_t              state_q, state_d;
    logic [7:0]          cnt_hi_q, cnt_hi_d;
    logic [15:0]         remaining_q, remaining_d;
    logic [7:0]          hi_q, hi_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [15:0]         wr_data_q, wr_data_d;
    logic                accept;
    logic [15:0]         word_count;
`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0]          xor_q, xor_d;
`endif

    assign word_count = {cnt_hi_q, in_data};
    assign accept     = in_valid && in_ready;

    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            S_HDR_HI, S_HDR_LO, S_DAT_HI, S_DAT_LO: in_ready = 1'b1;
`ifdef IMEM_LOADER_CKSUM_EN
            S_CKSUM:                                in_ready = 1'b1;
`endif
            default:                                in_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_hi_d    = cnt_hi_q;
        remaining_d = remaining_q;
        hi_d        = hi_q;
        wr_en_d     = 1'b0;
        wr_data_d   = wr_data_q;
        wr_addr_d   = wr_en_q ? wr_addr_q + ADDR_W'(1) : wr_addr_q;
`ifdef IMEM_LOADER_CKSUM_EN
        xor_d       = xor_q;
        if (accept && state_q != S_CKSUM) begin
            xor_d = xor_q ^ in_data;
        end
`endif
        if (accept) begin
            case (state_q)
                S_HDR_HI: begin
                    cnt_hi_d = in_data;
                    state_d  = S_HDR_LO;
                end
                S_HDR_LO: begin
                    remaining_d = word_count;
                    if (32'(word_count) > DEPTH) begin
                        state_d = S_ERR;
                    end else if (word_count == 16'd0) begin
                        state_d = S_END;
                    end else begin
                        state_d = S_DAT_HI;
                    end
                end
                S_DAT_HI: begin
                    hi_d    = in_data;
                    state_d = S_DAT_LO;
                end
                S_DAT_LO: begin
                    wr_data_d   = {hi_q, in_data};
                    wr_en_d     = 1'b1;
                    remaining_d = remaining_q - 16'd1;
                    state_d     = (remaining_q == 16'd1) ? S_END : S_DAT_HI;
                end
`ifdef IMEM_LOADER_CKSUM_EN
                S_CKSUM: begin
                    state_d = (in_data == xor_q) ? S_DONE : S_ERR;
                end
`endif
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_HDR_HI;
            cnt_hi_q    <= '0;
            remaining_q <= '0;
            hi_q        <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
            xor_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_hi_q    <= cnt_hi_d;
            remaining_q <= remaining_d;
            hi_q        <= hi_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
`ifdef IMEM_LOADER_CKSUM_EN
            xor_q       <= xor_d;
`endif
        end
    end

    // DONE is entered on the last LO byte; masking with the write strobe delays done past that write.
    assign done     = (state_q == S_DONE) && !wr_en_q;
    assign error    = (state_q == S_ERR);
    assign cpu_hold = !done;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: cycle table, directed corner sequences and randomized loads against a stream-level model.
module tb_imem_loader;
    localparam int unsigned DEPTH  = 256;
    localparam int unsigned ADDR_W = 8;
`ifdef IMEM_LOADER_CKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = '0;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic              cpu_hold;
    logic              done;
    logic              error;

    always #5 clk = ~clk;

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } wr_t;

    typedef struct {
        logic        rst_n;
        logic        v;
        logic [7:0]  d;
        logic [28:0] exp;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    bit          mon_en = 1'b0;
    logic        rdy_prev = 1'b0;
    wr_t         exp_q[$];
    logic [7:0]  stim_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (mon_en && wr_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", wr_addr, wr_data);
            end else begin
                if ({wr_addr, wr_data} !== {exp_q[0].addr, exp_q[0].data}) begin
                    failures++;
                    $display("FAIL write: got addr %h data %h expected addr %h data %h",
                             wr_addr, wr_data, exp_q[0].addr, exp_q[0].data);
                end
                void'(exp_q.pop_front());
            end
        end
        if (mon_en && done === 1'b1 && wr_en === 1'b1) begin
            failures++;
            $display("FAIL done_with_write: got done 1 wr_en 1 expected not both");
        end
        rdy_prev = in_ready;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Model: header, big-endian words, optional XOR byte; writes land at 0..N-1 only when N fits.
    task automatic build_load(input int unsigned n, input logic [15:0] words[$], input bit bad_ck);
        logic [7:0] ck;
        logic [15:0] n16;
        wr_t w;
        n16 = n[15:0];
        stim_q.delete();
        stim_q.push_back(n16[15:8]);
        stim_q.push_back(n16[7:0]);
        ck = n16[15:8] ^ n16[7:0];
        if (n <= DEPTH) begin
            for (int i = 0; i < int'(n); i++) begin
                stim_q.push_back(words[i][15:8]);
                stim_q.push_back(words[i][7:0]);
                ck = ck ^ words[i][15:8] ^ words[i][7:0];
                w.addr = ADDR_W'(i);
                w.data = words[i];
                exp_q.push_back(w);
            end
            if (CK) stim_q.push_back(bad_ck ? ~ck : ck);
        end else begin
            for (int i = 0; i < 4; i++) stim_q.push_back(8'($urandom));
        end
    endtask

    // mode 0: valid held high, 1: valid toggles every cycle, 2: random gaps
    task automatic feed(input int mode);
        int budget = 4000;
        bit tog = 1'b1;
        bit v;
        logic r;
        while (stim_q.size() > 0) begin
            if (!rdy_prev) break;
            case (mode)
                0:       v = 1'b1;
                1:       begin v = tog; tog = ~tog; end
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            in_valid = v;
            in_data  = stim_q[0];
            r = rdy_prev;
            step();
            if (v && r) void'(stim_q.pop_front());
            budget--;
            if (budget == 0) begin
                failures++;
                $display("FAIL feed_timeout: got %0d bytes left expected 0", stim_q.size());
                break;
            end
        end
        in_valid = 1'b0;
        stim_q.delete();
    endtask

    task automatic expect_end(input bit e_done, input bit e_err, input string tag);
        int n = 0;
        while (!(done === 1'b1 || error === 1'b1) && n < 8) begin
            step();
            n++;
        end
        check({tag, "_done"}, 32'(done), 32'(e_done));
        check({tag, "_error"}, 32'(error), 32'(e_err));
        check({tag, "_hold"}, 32'(cpu_hold), 32'(!e_done));
        check({tag, "_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
        in_valid = 1'b1;
        in_data  = 8'h5A;
        repeat (3) step();
        in_valid = 1'b0;
        check({tag, "_sticky"}, {30'd0, done, error}, {30'd0, e_done, e_err});
        exp_q.delete();
    endtask

    function automatic logic [28:0] mk(input bit r, input bit w, input logic [7:0] a,
                                       input logic [15:0] d, input bit dn, input bit er, input bit hd);
        return {r, w, a, d, dn, er, hd};
    endfunction

    initial begin
        vec_t vecs[12];
        logic [15:0] words[$];
        int unsigned n;
        bit bad;

        vecs[0]  = '{1'b0, 1'b0, 8'h00, mk(1, 0, 8'd0, 16'h0000, 0, 0, 1)};
        vecs[1]  = '{1'b0, 1'b0, 8'h00, mk(1, 0, 8'd0, 16'h0000, 0, 0, 1)};
        vecs[2]  = '{1'b1, 1'b1, 8'h00, mk(1, 0, 8'd0, 16'h0000, 0, 0, 1)};
        vecs[3]  = '{1'b1, 1'b1, 8'h03, mk(1, 0, 8'd0, 16'h0000, 0, 0, 1)};
        vecs[4]  = '{1'b1, 1'b1, 8'h20, mk(1, 0, 8'd0, 16'h0000, 0, 0, 1)};
        vecs[5]  = '{1'b1, 1'b1, 8'h01, mk(1, 1, 8'd0, 16'h2001, 0, 0, 1)};
        vecs[6]  = '{1'b1, 1'b1, 8'h4A, mk(1, 0, 8'd1, 16'h2001, 0, 0, 1)};
        vecs[7]  = '{1'b1, 1'b1, 8'h83, mk(1, 1, 8'd1, 16'h4A83, 0, 0, 1)};
        vecs[8]  = '{1'b1, 1'b1, 8'hFF, mk(1, 0, 8'd2, 16'h4A83, 0, 0, 1)};
        vecs[9]  = '{1'b1, 1'b1, 8'hFF, mk(CK, 1, 8'd2, 16'hFFFF, 0, 0, 1)};
        vecs[10] = '{1'b1, 1'b1, 8'hEB, mk(0, 0, 8'd3, 16'hFFFF, 1, 0, 0)};
        vecs[11] = '{1'b1, 1'b1, 8'hEB, mk(0, 0, 8'd3, 16'hFFFF, 1, 0, 0)};

        for (int i = 0; i < 12; i++) begin
            rst_n    = vecs[i].rst_n;
            in_valid = vecs[i].v;
            in_data  = vecs[i].d;
            step();
            check($sformatf("table_row%0d", i),
                  32'({in_ready, wr_en, wr_addr, wr_data, done, error, cpu_hold}),
                  32'(vecs[i].exp));
        end
        in_valid = 1'b0;
        mon_en = 1'b1;

        // Word count above DEPTH
        do_reset();
        words.delete();
        build_load(257, words, 1'b0);
        feed(0);
        expect_end(1'b0, 1'b1, "overflow");

        // Exactly DEPTH words is legal
        do_reset();
        words.delete();
        for (int i = 0; i < int'(DEPTH); i++) words.push_back(16'($urandom));
        build_load(DEPTH, words, 1'b0);
        feed(0);
        expect_end(1'b1, 1'b0, "full_depth");

        // Gapped stream
        do_reset();
        words = '{16'hBEEF, 16'h0102};
        build_load(2, words, 1'b0);
        feed(1);
        expect_end(1'b1, 1'b0, "gapped");

        // Reset mid-word, on the very edge that would have accepted the LO byte
        do_reset();
        exp_q.delete();
        stim_q = '{8'h00, 8'h04, 8'hAB};
        feed(0);
        check("midload_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = 8'hCD;
        rst_n    = 1'b0;
        step();
        check("midload_cancel", 32'(wr_en), 32'd0);
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        check("midload_addr", 32'(wr_addr), 32'd0);
        words = '{16'h1234};
        build_load(1, words, 1'b0);
        feed(0);
        expect_end(1'b1, 1'b0, "reload");

`ifdef IMEM_LOADER_CKSUM_EN
        do_reset();
        words = '{16'h1234};
        build_load(1, words, 1'b0);
        check("cksum_model", 32'(stim_q[4]), 32'h27);
        stim_q = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h27};
        feed(0);
        expect_end(1'b1, 1'b0, "cksum_good");
        do_reset();
        build_load(1, words, 1'b0);
        stim_q = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h00};
        feed(0);
        expect_end(1'b0, 1'b1, "cksum_bad");
`endif

        for (int it = 0; it < 24; it++) begin
            do_reset();
            words.delete();
            n = ($urandom_range(0, 5) == 0) ? $urandom_range(257, 400) : $urandom_range(0, 7);
            for (int i = 0; i < 8; i++) words.push_back(16'($urandom));
            bad = CK && ($urandom_range(0, 2) == 0);
            build_load(n, words, bad);
            feed(2);
            expect_end(n <= DEPTH && !bad, n > DEPTH || bad, $sformatf("rand%0d", it));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
